// File: rtl/rti_sequencer_pkg.sv
// Shared types and widths for the RET/RTI unstacking sequencer.
package rti_sequencer_pkg;

  localparam int PC_W   = 32;
  localparam int FLAG_W = 3;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP_FLAGS = 3'd1,
    ST_POP_LO    = 3'd2,
    ST_POP_HI    = 3'd3,
    ST_CAP_HI    = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/rti_sequencer.sv
// Pops flags (RTI only) and the return PC off the stack, then strobes the
// restored PC/flags into the core while holding the pipeline stalled.
module rti_sequencer
  import rti_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ret,
  input  logic              rti,
  input  logic [DATA_W-1:0] memDataIn,
  output logic              pop,
  output logic              memRead,
  output logic              stall,
  output logic              flush,
  output logic              pcLoad,
  output logic [PC_W-1:0]   pcOut,
  output logic              flagLoad,
  output logic [FLAG_W-1:0] flagOut
);

  seq_state_t          r_state;
  logic                r_is_rti;
  logic                r_pop;
  logic                r_stall;
  logic                r_flush;
  logic                r_pc_load;
  logic                r_flag_load;
  logic [PC_W-1:0]     r_pc;
  logic [FLAG_W-1:0]   r_flag;

  // Outputs are registered alongside the state: each transition sets the
  // values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_rti    <= 1'b0;
      r_pop       <= 1'b0;
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_flag_load <= 1'b0;
      r_pc        <= '0;
      r_flag      <= '0;
    end else begin
      r_pop       <= 1'b0;
      r_stall     <= 1'b1;
      r_flush     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_flag_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rti) begin
            r_state  <= ST_POP_FLAGS;
            r_is_rti <= 1'b1;
            r_pop    <= 1'b1;
          end else if (ret) begin
            r_state  <= ST_POP_LO;
            r_is_rti <= 1'b0;
            r_pop    <= 1'b1;
          end else begin
            r_stall  <= 1'b0;
          end
        end
        ST_POP_FLAGS: begin
          r_state <= ST_POP_LO;
          r_pop   <= 1'b1;
        end
        ST_POP_LO: begin
          // Data returned here is the flags word popped one cycle earlier.
          if (r_is_rti) begin
            r_flag <= memDataIn[FLAG_W-1:0];
          end
          r_state <= ST_POP_HI;
          r_pop   <= 1'b1;
        end
        ST_POP_HI: begin
          r_pc[DATA_W-1:0] <= memDataIn;
          r_state          <= ST_CAP_HI;
        end
        ST_CAP_HI: begin
          r_pc[PC_W-1:DATA_W] <= memDataIn;
          r_state             <= ST_DONE;
          r_pc_load           <= 1'b1;
          r_flush             <= 1'b1;
          r_flag_load         <= r_is_rti;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign pop      = r_pop;
  assign memRead  = r_pop;
  assign stall    = r_stall;
  assign flush    = r_flush;
  assign pcLoad   = r_pc_load;
  assign pcOut    = r_pc;
  assign flagLoad = r_flag_load;
  assign flagOut  = r_flag;

endmodule
